ysyx_23060096_ifu: RTL

Instruction fetch unit for the NPC core. It owns the architectural PC, fetches one 32-bit instruction at a time from instruction memory over a request/response handshake, and presents the fetched word plus its PC to the decode/control-generation stage over a valid/ready handshake. Redirects (branch, jump, trap) from execute replace the PC and squash any fetch already in flight. The design is non-pipelined: at most one outstanding memory request.

---
 rtl/ysyx_23060096_ifu.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to
// instruction memory and holds the fetched word for decode until consumed.
// Redirects replace the PC and squash any fetch already in flight.
module ysyx_23060096_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d;

  // Sequential PC advance; wraps modulo 2^32 with no flag.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || redirect_valid) begin
            // Response belongs to a squashed fetch; refetch from current pc.
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) begin
              pc_d = redirect_pc;
            end
          end else begin
            inst_d       = imem_rsp_data;
            inst_pc_d    = pc_q;
            inst_fault_d = imem_rsp_err;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end else if (redirect_valid) begin
          // Cannot cancel the outstanding request; remember to drop its data.
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          inst_valid_d = 1'b0;
          pc_d         = redirect_pc;
          state_d      = S_REQ;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          if (inst_fault_q) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = pc_incr(pc_q);
            state_d = S_REQ;
          end
        end
      end
      S_FAULT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, PC and instruction registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  // A redirect in REQ suppresses the request so the stale pc is never sent.
  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_fault     = inst_fault_q;

endmodule
